// File: rtl/axi_pkg.sv
// Shared AXI4 constants, the write-engine state type and a constant clog2 helper.
package axi_pkg;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [3:0] CACHE_DEFAULT = 4'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    DONE    = 3'd4
  } wr_state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry stream skid buffer; up_ready is registered so it never depends
// combinationally on dn_ready.
module axis_skid_buf #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [DATA_WIDTH-1:0] dn_data
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;
  logic [1:0]            count_next;
  logic                  ready_reg;
  logic                  push;
  logic                  pop;

  assign push     = up_valid && ready_reg;
  assign pop      = dn_ready && (count_reg != 2'd0);
  assign up_ready = ready_reg;
  assign dn_valid = (count_reg != 2'd0);
  assign dn_data  = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg + {1'b0, push} - {1'b0, pop};
  end

  // ready is the registered "not full" view of the next occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      ready_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      ready_reg <= (count_next != 2'd2);
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= up_data;
  end

endmodule

// File: rtl/axis_axi_write.sv
// Stream-to-AXI4 burst writer: NUM_BURSTS fixed-length INCR bursts per buffer pass.
// Optional feature macro BYTE_SWAP_EN byte-reverses the low 32 bits of each beat.
module axis_axi_write
  import axi_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 64,
  parameter int                  AW_LEN     = 64,
  parameter int                  NUM_BURSTS = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h1000_1000
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_areset,
  input  logic                    S_WR_tvalid,
  output logic                    S_WR_tready,
  input  logic [DATA_WIDTH-1:0]   S_WR_tdata,
  output logic                    o_wr_done,
  output logic                    o_wr_err,
  output logic                    m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic                    m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int BURST_BYTES = AW_LEN * BYTES;
  localparam int BURST_W     = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64 && DATA_WIDTH != 128) begin : g_bad_width
    $error("axis_axi_write: DATA_WIDTH must be 32, 64 or 128");
  end
  if (AW_LEN < 1 || AW_LEN > 256) begin : g_bad_len
    $error("axis_axi_write: AW_LEN must be 1..256");
  end
  // a burst may not straddle a 4 KB page
  if (BURST_BYTES > 4096) begin : g_bad_burst
    $error("axis_axi_write: AW_LEN*DATA_WIDTH/8 exceeds 4096 bytes");
  end

  wr_state_t               state_reg;
  wr_state_t               state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [7:0]              beat_reg;
  logic [BURST_W-1:0]      burst_reg;
  logic                    err_reg;
  logic                    buf_valid;
  logic [DATA_WIDTH-1:0]   buf_data;
  logic                    last_beat;
  logic                    last_burst;
  logic                    unused_bits;

  axis_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk      (m_axi_aclk),
    .rst      (m_axi_areset),
    .up_valid (S_WR_tvalid),
    .up_ready (S_WR_tready),
    .up_data  (S_WR_tdata),
    .dn_valid (buf_valid),
    .dn_ready (m_axi_wvalid && m_axi_wready),
    .dn_data  (buf_data)
  );

  assign m_axi_awid    = 1'b0;
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awlen   = 8'(AW_LEN - 1);
  assign m_axi_awsize  = 3'(clog2(BYTES));
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = CACHE_DEFAULT;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wstrb   = '1;
  assign o_wr_err      = err_reg;
  assign unused_bits   = m_axi_bid;

`ifdef BYTE_SWAP_EN
  genvar gi;
  for (gi = 0; gi < BYTES; gi++) begin : g_lane
    localparam int SRC = (gi < 4) ? (3 - gi) : gi;
    assign m_axi_wdata[gi*8 +: 8] = buf_data[SRC*8 +: 8];
  end
`else
  assign m_axi_wdata = buf_data;
`endif

  assign last_beat  = (beat_reg == 8'(AW_LEN - 1));
  assign last_burst = (burst_reg == BURST_W'(NUM_BURSTS - 1));

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) state_reg <= IDLE;
    else              state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    o_wr_done     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (buf_valid) state_next = WR_ADDR;
      end
      WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_next = WR_DATA;
      end
      WR_DATA: begin
        m_axi_wvalid = buf_valid;
        m_axi_wlast  = last_beat;
        if (buf_valid && m_axi_wready && last_beat) state_next = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_next = last_burst ? DONE : IDLE;
      end
      DONE: begin
        o_wr_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      addr_reg  <= BASE_ADDR;
      beat_reg  <= 8'd0;
      burst_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (m_axi_wvalid && m_axi_wready) begin
        beat_reg <= last_beat ? 8'd0 : beat_reg + 8'd1;
      end
      if (m_axi_bready && m_axi_bvalid) begin
        if (m_axi_bresp != RESP_OKAY) err_reg <= 1'b1;
        addr_reg  <= addr_reg + ADDR_WIDTH'(BURST_BYTES);
        burst_reg <= burst_reg + BURST_W'(1);
      end
      if (state_reg == DONE) begin
        addr_reg  <= BASE_ADDR;
        burst_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axis_axi_write.sv
// Directed bench for axis_axi_write: stream source, AXI write slave and memory log.
module tb_axis_axi_write;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        S_WR_tvalid = 1'b0;
  logic        S_WR_tready;
  logic [63:0] S_WR_tdata = 64'd0;
  logic        o_wr_done;
  logic        o_wr_err;
  logic        m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_awqos;
  logic        m_axi_awvalid;
  logic        awready = 1'b0;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        m_axi_bready;

  always #5 clk = ~clk;

  axis_axi_write dut (
    .m_axi_aclk    (clk),
    .m_axi_areset  (rst),
    .S_WR_tvalid   (S_WR_tvalid),
    .S_WR_tready   (S_WR_tready),
    .S_WR_tdata    (S_WR_tdata),
    .o_wr_done     (o_wr_done),
    .o_wr_err      (o_wr_err),
    .m_axi_awid    (m_axi_awid),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_awlock  (m_axi_awlock),
    .m_axi_awcache (m_axi_awcache),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awqos   (m_axi_awqos),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (wready),
    .m_axi_bid     (1'b0),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (m_axi_bready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scenario configuration
  int          aw_delay  = 0;
  bit          wmode     = 1'b0;
  bit          gap       = 1'b0;
  int          err_burst = -1;
  int          src_total = 0;
  logic [63:0] data_base = 64'd0;

  // source / slave state and transaction log
  int          src_idx = 0;
  bit          src_acc = 1'b0;
  int          aw_wait = 0;
  int          aw_hold = 0;
  logic [31:0] aw_first = 32'd0;
  bit          aw_open = 1'b0;
  bit          pend_b = 1'b0;
  int          b_idx = 0;
  int          cyc = 0;
  bit          err_chk_next = 1'b0;
  logic        err_at_hs = 1'b0;
  logic        err_next = 1'b0;
  logic [31:0] aw_q[$];
  int          hold_q[$];
  logic [63:0] w_q[$];
  int          wlast_q[$];
  int          done_cnt = 0;
  int          viol = 0;

  function automatic logic [63:0] expw(input logic [63:0] d);
`ifdef BYTE_SWAP_EN
    return {d[63:32], d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // inputs change at negedge; everything the next posedge will see is logged at negedge+1
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        S_WR_tvalid = 1'b0;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
      end else begin
        cyc++;
        if (err_chk_next) begin
          err_next     = o_wr_err;
          err_chk_next = 1'b0;
        end
        if (o_wr_done) done_cnt++;
        if (!S_WR_tvalid || src_acc) begin
          if (src_idx < src_total) begin
            S_WR_tvalid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
            S_WR_tdata  = data_base + 64'(src_idx);
          end else begin
            S_WR_tvalid = 1'b0;
          end
        end
        src_acc = 1'b0;
        awready = m_axi_awvalid && (aw_wait >= aw_delay);
        wready  = wmode ? (cyc % 3 == 0) : 1'b1;
        bvalid  = pend_b;
        bresp   = (b_idx == err_burst) ? 2'b10 : 2'b00;
        #1;
        if (S_WR_tvalid && S_WR_tready) begin
          src_acc = 1'b1;
          src_idx++;
        end
        if (m_axi_awvalid) begin
          if (aw_hold == 0) aw_first = m_axi_awaddr;
          else if (m_axi_awaddr !== aw_first) viol++;
          aw_hold++;
          if (awready) begin
            aw_q.push_back(m_axi_awaddr);
            hold_q.push_back(aw_hold);
            aw_hold = 0;
            aw_wait = 0;
            aw_open = 1'b1;
          end else begin
            aw_wait++;
          end
        end
        if (m_axi_wvalid && !aw_open) viol++;
        if (m_axi_wvalid && wready) begin
          w_q.push_back(m_axi_wdata);
          if (m_axi_wlast) begin
            wlast_q.push_back(w_q.size() - 1);
            aw_open = 1'b0;
            pend_b  = 1'b1;
          end
        end
        if (bvalid && m_axi_bready) begin
          pend_b = 1'b0;
          if (b_idx == err_burst) begin
            err_at_hs    = o_wr_err;
            err_chk_next = 1'b1;
          end
          b_idx++;
        end
      end
    end
  end

  task automatic do_reset(input string tag);
    @(negedge clk);
    #3;
    rst = 1'b1;
    src_total = 0; src_idx = 0; src_acc = 1'b0;
    aw_wait = 0; aw_hold = 0; aw_open = 1'b0; pend_b = 1'b0;
    b_idx = 0; cyc = 0; err_chk_next = 1'b0; err_at_hs = 1'b0; err_next = 1'b0;
    aw_q.delete(); hold_q.delete(); w_q.delete(); wlast_q.delete();
    done_cnt = 0; viol = 0;
    repeat (2) @(negedge clk);
    #1;
    check({tag, "_rst_awvalid"}, 64'(m_axi_awvalid), 64'd0);
    check({tag, "_rst_wvalid"},  64'(m_axi_wvalid),  64'd0);
    check({tag, "_rst_wlast"},   64'(m_axi_wlast),   64'd0);
    check({tag, "_rst_bready"},  64'(m_axi_bready),  64'd0);
    check({tag, "_rst_done"},    64'(o_wr_done),     64'd0);
    check({tag, "_rst_err"},     64'(o_wr_err),      64'd0);
    check({tag, "_rst_tready"},  64'(S_WR_tready),   64'd0);
    rst = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_pass(input string tag);
    int bad;
    bad = 0;
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_aw_cnt"},   64'(aw_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_a;
      logic [31:0] got_a;
      exp_a = 32'h1000_1000 + 32'(i) * 32'h200;
      got_a = (i < aw_q.size()) ? aw_q[i] : 32'hxxxx_xxxx;
      check($sformatf("%s_awaddr%0d", tag, i), 64'(got_a), 64'(exp_a));
      check($sformatf("%s_wlast%0d", tag, i),
            (i < wlast_q.size()) ? 64'(wlast_q[i]) : 64'hffff_ffff, 64'(64 * i + 63));
    end
    check({tag, "_w_cnt"}, 64'(w_q.size()), 64'd256);
    for (int k = 0; k < w_q.size(); k++) begin
      if (w_q[k] !== expw(data_base + 64'(k))) bad++;
    end
    check({tag, "_data_order"}, 64'(bad), 64'd0);
    check({tag, "_protocol"}, 64'(viol), 64'd0);
    $display("scenario %s: aw=%0d beats=%0d done=%0d err=%0b", tag, aw_q.size(), w_q.size(), done_cnt, o_wr_err);
  endtask

  initial begin
    // 1: always-ready slave, back-to-back stream
    do_reset("s1");
    check("s1_awlen",   64'(m_axi_awlen),   64'd63);
    check("s1_awsize",  64'(m_axi_awsize),  64'd3);
    check("s1_awburst", 64'(m_axi_awburst), 64'd1);
    check("s1_awcache", 64'(m_axi_awcache), 64'd3);
    check("s1_wstrb",   64'(m_axi_wstrb),   64'hff);
    data_base = 64'h0000_0000_1122_3344;
    aw_delay = 0; wmode = 1'b0; gap = 1'b0; err_burst = -1;
    src_total = 256;
    wait_done();
    check_pass("s1");
    check("s1_err", 64'(o_wr_err), 64'd0);
`ifdef BYTE_SWAP_EN
    check("s1_swap", (w_q.size() > 0) ? w_q[0] : 64'hx, 64'h0000_0000_4433_2211);
`else
    check("s1_swap", (w_q.size() > 0) ? w_q[0] : 64'hx, 64'h0000_0000_1122_3344);
`endif

    // 2: awready held off for 5 cycles on every burst
    do_reset("s2");
    data_base = 64'hA000_0000_0000_0000;
    aw_delay = 5;
    src_total = 256;
    wait_done();
    check_pass("s2");
    for (int i = 0; i < 4; i++)
      check($sformatf("s2_awhold%0d", i), (i < hold_q.size()) ? 64'(hold_q[i]) : 64'd0, 64'd6);

    // 3: wready 1-of-3 with random source gaps
    do_reset("s3");
    data_base = 64'h3300_0000_0000_0000;
    aw_delay = 0; wmode = 1'b1; gap = 1'b1;
    src_total = 256;
    wait_done();
    check_pass("s3");

    // 4: SLVERR on burst 2
    do_reset("s4");
    data_base = 64'h4400_0000_0000_0000;
    wmode = 1'b0; gap = 1'b0; err_burst = 2;
    src_total = 256;
    wait_done();
    check_pass("s4");
    check("s4_err_before", 64'(err_at_hs), 64'd0);
    check("s4_err_next",   64'(err_next),  64'd1);
    check("s4_err_sticky", 64'(o_wr_err),  64'd1);
    err_burst = -1;

    // 5: reset at beat 30 of burst 1, then a full fresh pass
    do_reset("s5a");
    data_base = 64'h5000_0000_0000_0000;
    src_total = 256;
    for (int i = 0; i < 2000 && w_q.size() < 94; i++) @(negedge clk);
    check("s5_reached_beat94", 64'(w_q.size() >= 94), 64'd1);
    check("s5_no_early_done", 64'(done_cnt), 64'd0);
    do_reset("s5b");
    data_base = 64'h5555_0000_0000_0000;
    src_total = 256;
    wait_done();
    check_pass("s5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_axi_write.md
AXIS_AXI_WRITE -- requirements
Module: axis_axi_write

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: AXI address width.
REQ-002 Parameter DATA_WIDTH, default 64: stream and AXI data width; legal values are 32, 64 and 128.
REQ-003 Parameter AW_LEN, default 64: beats per burst, range 1..256.
REQ-004 Parameter NUM_BURSTS, default 4: bursts per buffer pass.
REQ-005 Parameter BASE_ADDR, default 32'h1000_1000: first burst address, aligned to 4 KB.
REQ-006 Ports, clock and reset first:
- m_axi_aclk, in, 1: sole clock.
- m_axi_areset, in, 1: asynchronous active-high reset.
- S_WR_tvalid, in, 1; S_WR_tready, out, 1; S_WR_tdata, in, DATA_WIDTH: input stream.
- o_wr_done, out, 1: one-cycle pulse when a buffer pass completes.
- o_wr_err, out, 1: sticky write-response error flag.
- m_axi_awid, out, 1; m_axi_awaddr, out, ADDR_WIDTH; m_axi_awlen, out, 8; m_axi_awsize, out, 3; m_axi_awburst, out, 2; m_axi_awlock, out, 1; m_axi_awcache, out, 4; m_axi_awprot, out, 3; m_axi_awqos, out, 4; m_axi_awvalid, out, 1; m_axi_awready, in, 1.
- m_axi_wdata, out, DATA_WIDTH; m_axi_wstrb, out, DATA_WIDTH/8; m_axi_wlast, out, 1; m_axi_wvalid, out, 1; m_axi_wready, in, 1.
- m_axi_bid, in, 1; m_axi_bresp, in, 2; m_axi_bvalid, in, 1; m_axi_bready, out, 1.
REQ-007 The design SHALL use one clock, m_axi_aclk, and SHALL treat m_axi_areset as an asynchronous, active-high reset.

Function
REQ-008 The following outputs SHALL be constant: awid=0, awlock=0, awcache=4'd3, awprot=0, awqos=0, awburst=2'b01 (INCR), awsize=clog2(DATA_WIDTH/8), awlen=AW_LEN-1, wstrb=all ones.
REQ-009 The stream SHALL enter through a 2-entry skid buffer.
- S_WR_tready is high whenever the buffer is not full, in every state.
- There is no combinational path from m_axi_wready to S_WR_tready.
REQ-010 The FSM SHALL have the states IDLE, WR_ADDR, WR_DATA, WR_RESP and DONE.
REQ-011 IDLE->WR_ADDR SHALL occur when the skid buffer is non-empty. awvalid rises on the next cycle with awaddr=cur_addr.
REQ-012 In WR_ADDR, awvalid and awaddr SHALL hold until awready is sampled high, and the FSM then moves to WR_DATA. awvalid never drops without a handshake.
REQ-013 In WR_DATA, the W channel SHALL be driven as follows:
- wvalid = buffer non-empty; the buffer pops on wvalid&&wready.
- The beat counter increments on each W handshake.
- wlast = (beat counter == AW_LEN-1).
- The handshake with wlast high moves the FSM to WR_RESP and clears the counter.
REQ-014 Outside WR_DATA, wvalid SHALL be 0 and wlast SHALL be 0.
REQ-015 bready SHALL be 1 only in WR_RESP. On bvalid:
- If bresp!=2'b00, o_wr_err is set.
- cur_addr advances by AW_LEN*DATA_WIDTH/8.
- The burst counter increments.
REQ-016 From WR_RESP, the next state SHALL be DONE if this was burst NUM_BURSTS-1, else IDLE.
REQ-017 In DONE, o_wr_done SHALL pulse for exactly one cycle, cur_addr SHALL return to BASE_ADDR, the burst counter SHALL clear, and the FSM SHALL go to IDLE.
REQ-018 The address SHALL never cross a 4 KB boundary within a burst; AW_LEN*DATA_WIDTH/8 > 4096 is a compile-time error.
REQ-019 o_wr_err SHALL clear only on reset.
REQ-020 The stream SHALL stall, with no data lost, when m_axi_wready is low or when the FSM is not in WR_DATA.

Reset
REQ-021 On reset, the design SHALL enter IDLE and SHALL drive awvalid, wvalid, wlast, bready, o_wr_done, o_wr_err and S_WR_tready to 0.
REQ-022 On reset, the skid buffer SHALL be emptied, cur_addr SHALL be set to BASE_ADDR, and the beat and burst counters SHALL be cleared.
REQ-023 Reset asserted mid-burst SHALL abandon the burst silently; no o_wr_done is produced.

Configuration
REQ-024 With `BYTE_SWAP_EN defined, m_axi_wdata[31:0] SHALL be the byte-reversed S_WR_tdata[31:0] and the upper bits SHALL pass straight through.
REQ-025 Without `BYTE_SWAP_EN, m_axi_wdata SHALL equal the buffered tdata unchanged.

Structure
REQ-026 A shared package axi_pkg SHALL hold the AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00, CACHE_DEFAULT=4'd3, and the clog2 function.
REQ-027 The skid buffer SHALL be the sub-module axis_skid_buf, parameterised by DATA_WIDTH.

Verification
REQ-028 Defaults, always-ready slave, 256 incrementing beats -> bursts at 0x1000_1000, 0x1000_1200, 0x1000_1400 and 0x1000_1600; wlast on beats 63/127/191/255; one o_wr_done pulse.
REQ-029 awready delayed 5 cycles -> awvalid and awaddr stable for 6 cycles; no wvalid before the AW handshake.
REQ-030 wready toggling 1-of-3 cycles plus random tvalid gaps -> memory model holds every beat in order, with no duplicates or drops.
REQ-031 bresp=2'b10 on burst 2 -> o_wr_err=1 from the following cycle, the next address is still 0x1000_1600, and o_wr_done still pulses.
REQ-032 Reset asserted at beat 30 of burst 1, then 256 new beats -> restart at 0x1000_1000; exactly one o_wr_done after reset.
REQ-033 `BYTE_SWAP_EN defined, tdata 64'h0000_0000_1122_3344 -> wdata 64'h0000_0000_4433_2211.
